// File: rtl/guitar_pkg.sv
// Shared types and scoring constants for the per-lane note judges.
package guitar_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FALLING = 2'd1,
    JUDGED  = 2'd2
  } judge_state_t;

  localparam logic [4:0] PTS_GOOD    = 5'd10;
  localparam logic [4:0] PTS_PERFECT = 5'd20;
  localparam logic [7:0] MULT_STEP   = 8'd8;

  // Multiplier climbs one step every MULT_STEP consecutive hits, capped at 4.
  function automatic logic [2:0] mult_of(input logic [7:0] streak);
    if (streak < MULT_STEP)                            return 3'd1;
    else if (streak < (MULT_STEP << 1))                return 3'd2;
    else if (streak < (MULT_STEP + (MULT_STEP << 1)))  return 3'd3;
    else                                               return 3'd4;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector; the delayed bit's reset value is a parameter so a
// level held through reset can be kept from producing a spurious edge.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge Clk) begin
    if (Reset) d_q <= RST_VAL;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/note_judge.sv
// Per-lane note judge: grades key presses against the falling note position
// and keeps the lane's score, streak and multiplier.
module note_judge
  import guitar_pkg::*;
#(
  parameter logic [9:0] HIT_Y_MIN  = 10'd400,
  parameter logic [9:0] HIT_Y_MAX  = 10'd460,
  parameter logic [9:0] PERF_Y_MIN = 10'd420,
  parameter logic [9:0] PERF_Y_MAX = 10'd440
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        key_press,
  input  logic        note_active,
  input  logic [9:0]  note_y_pos,
  output logic        hit_pulse,
  output logic        perfect_pulse,
  output logic        miss_pulse,
  output logic [15:0] score,
  output logic [7:0]  streak,
  output logic [2:0]  multiplier,
  output logic [1:0]  judge_state
);

  judge_state_t state_q, state_d;
  logic [15:0]  score_q, score_d;
  logic [7:0]   streak_q, streak_d;
  logic         hit_q, hit_d, perf_q, perf_d, miss_q, miss_d;
  logic         key_rise;

  logic         in_perf;
  logic [4:0]   pts;
  logic [2:0]   mult;
  logic [6:0]   add;
  logic [16:0]  sum;

  rise_detect #(.RST_VAL(1'b1)) u_key_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (key_press),
    .rise  (key_rise)
  );

  assign in_perf = (note_y_pos >= PERF_Y_MIN) && (note_y_pos <= PERF_Y_MAX);
  assign pts     = in_perf ? PTS_PERFECT : PTS_GOOD;
  // Score uses the multiplier of the streak before this hit is counted.
  assign mult    = mult_of(streak_q);
  assign add     = {2'b00, pts} * {4'b0000, mult};
  assign sum     = {1'b0, score_q} + {10'd0, add};

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    streak_d = streak_q;
    hit_d    = 1'b0;
    perf_d   = 1'b0;
    miss_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (note_active) state_d = FALLING;
        if (key_rise) begin
          miss_d   = 1'b1;
          streak_d = 8'd0;
        end
      end
      FALLING: begin
        // A note leaving the window wins over a simultaneous press.
        if (!note_active || (note_y_pos > HIT_Y_MAX)) begin
          miss_d   = 1'b1;
          streak_d = 8'd0;
          state_d  = JUDGED;
        end else if (key_rise && (note_y_pos >= HIT_Y_MIN)) begin
          hit_d    = 1'b1;
          perf_d   = in_perf;
          score_d  = sum[16] ? 16'hFFFF : sum[15:0];
          streak_d = (streak_q == 8'hFF) ? 8'hFF : streak_q + 8'd1;
          state_d  = JUDGED;
        end else if (key_rise) begin
          miss_d   = 1'b1;
          streak_d = 8'd0;
        end
      end
      JUDGED: begin
        if (!note_active) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      score_q  <= 16'd0;
      streak_q <= 8'd0;
      hit_q    <= 1'b0;
      perf_q   <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      streak_q <= streak_d;
      hit_q    <= hit_d;
      perf_q   <= perf_d;
      miss_q   <= miss_d;
    end
  end

  assign hit_pulse     = hit_q;
  assign perfect_pulse = perf_q;
  assign miss_pulse    = miss_q;
  assign score         = score_q;
  assign streak        = streak_q;
  assign multiplier    = mult;
  assign judge_state   = state_q;

endmodule
